cfa_pass_sequencer: RTL and testbench

CFA_PASS_SEQUENCER -- requirements
Module: cfa_pass_sequencer

---
 rtl/cfa_pkg.sv | 45 ++++
 rtl/cfa_tag_delay.sv | 43 ++++
 rtl/cfa_pass_sequencer.sv | 115 +++++++++++
 tb/tb_cfa_pass_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfa_pkg.sv
// Shared codes for the CFA pass sequencer: FSM states, pass selects,
// write-enable bit positions and bayer colour codes.
package cfa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_G_START  = 3'd1,
    ST_G_RUN    = 3'd2,
    ST_G_DRAIN  = 3'd3,
    ST_RB_START = 3'd4,
    ST_RB_RUN   = 3'd5,
    ST_RB_DRAIN = 3'd6,
    ST_DONE     = 3'd7
  } seq_state_e;

  localparam logic [1:0] PASS_NONE = 2'b00;
  localparam logic [1:0] PASS_G    = 2'b01;
  localparam logic [1:0] PASS_RB   = 2'b10;

  localparam int GREEN_BIT = 2;
  localparam int RED_BIT   = 1;
  localparam int BLUE_BIT  = 0;

  localparam logic [1:0] BAYER_GREEN = 2'b01;
  localparam logic [1:0] BAYER_RED   = 2'b10;
  localparam logic [1:0] BAYER_BLUE  = 2'b11;

  localparam logic TAG_G  = 1'b0;
  localparam logic TAG_RB = 1'b1;

  function automatic logic [2:0] tag_to_we(input logic vld, input logic tag);
    logic [2:0] we;
    we = 3'b000;
    if (vld) begin
      if (tag == TAG_RB) begin
        we[RED_BIT]  = 1'b1;
        we[BLUE_BIT] = 1'b1;
      end else begin
        we[GREEN_BIT] = 1'b1;
      end
    end
    return we;
  endfunction

endpackage

// File: rtl/cfa_tag_delay.sv
// DEPTH-stage shift register carrying a valid bit and a pass tag.
// vld_next_o is the value about to enter the final stage.
module cfa_tag_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_i,
  input  logic tag_i,
  output logic vld_o,
  output logic tag_o,
  output logic vld_next_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] tag_q, tag_d;

  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = vld_i;
    tag_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign vld_o      = vld_q[DEPTH-1];
  assign tag_o      = tag_q[DEPTH-1];
  assign vld_next_o = vld_d[DEPTH-1];

endmodule

// File: rtl/cfa_pass_sequencer.sv
// CFA pass sequencer: runs the green pass then the R/B pass for one frame and
// times the interpolator write strobes through a pass-tagged delay line.
module cfa_pass_sequencer
  import cfa_pkg::*;
#(
  parameter int PIPE_LAT        = 3,
  parameter int addressBitWidth = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       colUpdate,
  input  logic                       addrDone,
  output logic                       addrStart,
  output logic [1:0]                 passSel,
  output logic [2:0]                 writeEnable,
  output logic [addressBitWidth-1:0] writeCount,
  output logic                       busy,
  output logic                       frameDone
);

  localparam logic [2:0] DRAIN_LOAD = 3'(PIPE_LAT - 1);

  seq_state_e                 state_q, state_d;
  logic [2:0]                 drain_q, drain_d;
  logic                       addr_start_q, addr_start_d;
  logic [1:0]                 pass_sel_q, pass_sel_d;
  logic                       busy_q, busy_d;
  logic                       frame_done_q, frame_done_d;
  logic [addressBitWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic                       col_acc, col_tag;
  logic                       dly_vld, dly_tag, dly_vld_next;

  assign col_acc = colUpdate && ((state_q == ST_G_RUN) || (state_q == ST_RB_RUN));
  assign col_tag = (state_q == ST_RB_RUN) ? TAG_RB : TAG_G;

  cfa_tag_delay #(.DEPTH(PIPE_LAT)) u_tag_delay (
    .clk        (clk),
    .rst        (rst),
    .vld_i      (col_acc),
    .tag_i      (col_tag),
    .vld_o      (dly_vld),
    .tag_o      (dly_tag),
    .vld_next_o (dly_vld_next)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE:     if (start) state_d = ST_G_START;
      ST_G_START:  state_d = ST_G_RUN;
      ST_G_RUN:    if (addrDone) begin
                     state_d = ST_G_DRAIN;
                     drain_d = DRAIN_LOAD;
                   end
      ST_G_DRAIN:  if (drain_q == 3'd0) state_d = ST_RB_START;
                   else drain_d = drain_q - 3'd1;
      ST_RB_START: state_d = ST_RB_RUN;
      ST_RB_RUN:   if (addrDone) begin
                     state_d = ST_RB_DRAIN;
                     drain_d = DRAIN_LOAD;
                   end
      ST_RB_DRAIN: if (drain_q == 3'd0) state_d = ST_DONE;
                   else drain_d = drain_q - 3'd1;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    addr_start_d = (state_d == ST_G_START) || (state_d == ST_RB_START);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
    pass_sel_d   = PASS_NONE;
    case (state_d)
      ST_G_START, ST_G_RUN, ST_G_DRAIN:    pass_sel_d = PASS_G;
      ST_RB_START, ST_RB_RUN, ST_RB_DRAIN: pass_sel_d = PASS_RB;
      default:                             pass_sel_d = PASS_NONE;
    endcase

    wr_cnt_d = wr_cnt_q;
    if (addr_start_d) wr_cnt_d = '0;
    else if (dly_vld_next) wr_cnt_d = wr_cnt_q + addressBitWidth'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      drain_q      <= '0;
      addr_start_q <= 1'b0;
      pass_sel_q   <= PASS_NONE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wr_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      addr_start_q <= addr_start_d;
      pass_sel_q   <= pass_sel_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  // writeEnable is a pure decode of the final delay flop; writeCount already
  // includes the write being presented in the same cycle.
  assign writeEnable = tag_to_we(dly_vld, dly_tag);
  assign addrStart   = addr_start_q;
  assign passSel     = pass_sel_q;
  assign busy        = busy_q;
  assign frameDone   = frame_done_q;
  assign writeCount  = wr_cnt_q;

endmodule

// File: tb/tb_cfa_pass_sequencer.sv
// Scoreboard bench for cfa_pass_sequencer: a frame planner predicts event
// times from the pass rules; a monitor compares DUT events as they appear.
module tb_cfa_pass_sequencer;

  localparam int P  = 3;
  localparam int AW = 17;

  localparam logic [1:0] PS_NONE = 2'b00;
  localparam logic [1:0] PS_G    = 2'b01;
  localparam logic [1:0] PS_RB   = 2'b10;
  localparam int EV_START = 0;
  localparam int EV_WRITE = 1;
  localparam int EV_DONE  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, colUpdate = 1'b0, addrDone = 1'b0;

  logic          addrStart, busy, frameDone;
  logic [1:0]    passSel;
  logic [2:0]    writeEnable;
  logic [AW-1:0] writeCount;

  logic          addrStart1, busy1, frameDone1;
  logic [1:0]    passSel1;
  logic [2:0]    writeEnable1;
  logic [AW-1:0] writeCount1;

  cfa_pass_sequencer #(.PIPE_LAT(P), .addressBitWidth(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .colUpdate(colUpdate), .addrDone(addrDone),
    .addrStart(addrStart), .passSel(passSel), .writeEnable(writeEnable),
    .writeCount(writeCount), .busy(busy), .frameDone(frameDone)
  );

  cfa_pass_sequencer #(.PIPE_LAT(1), .addressBitWidth(AW)) dut_p1 (
    .clk(clk), .rst(rst), .start(start), .colUpdate(colUpdate), .addrDone(addrDone),
    .addrStart(addrStart1), .passSel(passSel1), .writeEnable(writeEnable1),
    .writeCount(writeCount1), .busy(busy1), .frameDone(frameDone1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    int         kind;
    logic [2:0] we;
    logic [1:0] ps;
    int         cnt;
  } ev_t;

  ev_t exp_q[$];
  int  exp_lvl[int];
  ev_t mon_ev;
  bit  mon_en = 1'b0;
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected event whenever the DUT presents one.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
          mon_ev = exp_q.pop_front();
          check("missed_event_time", cyc, mon_ev.t);
        end
        if (addrStart || frameDone || (writeEnable != 3'b000)) begin
          if (exp_q.size() == 0 || exp_q[0].t != cyc) begin
            check("unexpected_event", int'({addrStart, frameDone, writeEnable}), 0);
          end else begin
            mon_ev = exp_q.pop_front();
            check("addrStart", int'(addrStart), int'(mon_ev.kind == EV_START));
            check("frameDone", int'(frameDone), int'(mon_ev.kind == EV_DONE));
            check("writeEnable", int'(writeEnable), int'(mon_ev.we));
            check("event_passSel", int'(passSel), int'(mon_ev.ps));
            if (mon_ev.kind == EV_WRITE) check("writeCount", int'(writeCount), mon_ev.cnt);
          end
        end
        if (exp_lvl.exists(cyc)) begin
          check("busy_passSel", int'({busy, passSel}), exp_lvl[cyc]);
          exp_lvl.delete(cyc);
        end
      end
    end
  end

  // Plans one frame: IDLE gap, start, green pass of lg RUN cycles, R/B pass of
  // lrb RUN cycles. Every expected event is queued before its cycle arrives.
  task automatic run_frame(input int gap, input int lg, input int lrb, input int density);
    int s, r, done, c, ng, nrb;
    bit g_run, rb_run;
    ng = 0;
    nrb = 0;
    repeat (gap) begin
      step();
      exp_lvl[cyc] = 0;
      start     = 1'b0;
      colUpdate = 1'($urandom_range(0, 1));
      addrDone  = 1'($urandom_range(0, 1));
    end
    step();
    s    = cyc;
    r    = s + 2 + lg + P;
    done = r + lrb + P + 1;
    exp_q.push_back('{t: s + 1, kind: EV_START, we: 3'b000, ps: PS_G, cnt: 0});
    for (int k = 0; k <= done - s; k++) begin
      if (k > 0) step();
      c      = cyc;
      g_run  = (c >= s + 2) && (c <= s + 1 + lg);
      rb_run = (c >= r + 1) && (c <= r + lrb);
      start  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      colUpdate = ($urandom_range(0, 99) < density);
      if (c == s + 1 + lg || c == r + lrb) addrDone = 1'b1;
      else if (g_run || rb_run) addrDone = 1'b0;
      else addrDone = 1'($urandom_range(0, 1));
      if (colUpdate && g_run) begin
        ng++;
        exp_q.push_back('{t: c + P, kind: EV_WRITE, we: 3'b100, ps: PS_G, cnt: ng});
      end
      if (colUpdate && rb_run) begin
        nrb++;
        exp_q.push_back('{t: c + P, kind: EV_WRITE, we: 3'b011, ps: PS_RB, cnt: nrb});
      end
      if (c == s + 1 + lg)
        exp_q.push_back('{t: r, kind: EV_START, we: 3'b000, ps: PS_RB, cnt: 0});
      if (c == r + lrb)
        exp_q.push_back('{t: done, kind: EV_DONE, we: 3'b000, ps: PS_NONE, cnt: 0});
      if (k == 0)        exp_lvl[c] = 0;
      else if (c < r)    exp_lvl[c] = int'({1'b1, PS_G});
      else if (c < done) exp_lvl[c] = int'({1'b1, PS_RB});
      else               exp_lvl[c] = int'({1'b1, PS_NONE});
    end
  endtask

  initial begin : stim
    #2;
    check("reset_outputs", int'({addrStart, passSel, writeEnable, writeCount, busy, frameDone}), 0);
    check("reset_outputs_p1", int'({addrStart1, passSel1, writeEnable1, writeCount1, busy1, frameDone1}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // PIPE_LAT=1 instance: write one cycle after colUpdate, one-cycle drains.
    step(); start = 1'b1;
    step(); start = 1'b0;
    @(negedge clk); check("p1_addrStart_g", int'(addrStart1), 1);
    step(); colUpdate = 1'b1;
    step(); colUpdate = 1'b0; addrDone = 1'b1;
    @(negedge clk);
    check("p1_we_green", int'(writeEnable1), 3'b100);
    check("p1_count_green", int'(writeCount1), 1);
    step(); addrDone = 1'b0;
    @(negedge clk);
    check("p1_drain_passSel", int'({addrStart1, passSel1, writeEnable1}), int'({1'b0, PS_G, 3'b000}));
    check("main_we_green", int'(writeEnable), 0);
    step();
    @(negedge clk);
    check("p1_rb_start", int'({addrStart1, passSel1}), int'({1'b1, PS_RB}));
    check("p1_count_cleared", int'(writeCount1), 0);
    check("main_we_green_lat3", int'(writeEnable), 3'b100);
    step(); colUpdate = 1'b1; addrDone = 1'b1;
    step(); colUpdate = 1'b0; addrDone = 1'b0;
    @(negedge clk);
    check("p1_we_rb", int'(writeEnable1), 3'b011);
    check("p1_count_rb", int'(writeCount1), 1);
    step();
    @(negedge clk); check("p1_frameDone", int'({frameDone1, busy1, passSel1}), int'({1'b1, 1'b1, PS_NONE}));
    step();
    @(negedge clk); check("p1_idle", int'({frameDone1, busy1}), 0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_lvl.delete();
    mon_en = 1'b1;

    run_frame(1, 10, 10, 0);
    run_frame(1, 4, 4, 100);
    for (int f = 0; f < 12; f++)
      run_frame($urandom_range(0, 3), $urandom_range(1, 12), $urandom_range(1, 12),
                $urandom_range(20, 80));
    step(); start = 1'b0; colUpdate = 1'b0; addrDone = 1'b0;
    repeat (P + 3) step();
    check("pending_events", exp_q.size(), 0);
    mon_en = 1'b0;

    // Asynchronous reset one cycle after an accepted green colUpdate.
    step(); start = 1'b1;
    step(); start = 1'b0;
    step(); colUpdate = 1'b1;
    step(); colUpdate = 1'b0;
    @(negedge clk); check("busy_before_rst", int'({busy, passSel}), int'({1'b1, PS_G}));
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", int'({addrStart, passSel, writeEnable, writeCount, busy, frameDone}), 0);
    step();
    step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); colUpdate = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("post_rst_quiet", int'({writeEnable, busy, passSel}), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
